// File: rtl/fetch_stage_pkg.sv
// Shared processor types: datapath widths, the fetch-buffer entry and the fetch FSM states.
package fetch_stage_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 16;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry circular FIFO between fetch and decode; head is a register mux, no bypass.
// Flush wins over push/pop; push while full is accepted only together with a pop.
module fetch_buffer #(
  parameter type entry_t = fetch_stage_pkg::fetch_entry_t
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  entry_t     push_data,
  input  logic       pop,
  input  logic       flush,
  output entry_t     head,
  output logic [1:0] count,
  output logic       full,
  output logic       empty
);

  entry_t     mem [2];
  logic       rd_ptr;
  logic       wr_ptr;
  logic       push_ok;
  logic       pop_ok;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign pop_ok  = pop && !empty;
  // A push into a full buffer only lands when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, RUN/DONE FSM, redirect handling, 2-entry output buffer.
// One cycle memory-to-output latency, one instr/cycle; stalls (PC holds) when the buffer is full.
module fetch_stage #(
  parameter int                               PC_W     = fetch_stage_pkg::PC_W,
  parameter int                               INSTR_W  = fetch_stage_pkg::INSTR_W,
  parameter logic [PC_W-1:0]                  RESET_PC = '0,
  parameter int                               PC_LIMIT = 32
) (
  input  logic               clk,
  input  logic               rst,
  output logic [PC_W-1:0]    imem_pc,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic               fetch_done
);

  import fetch_stage_pkg::*;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  // A limit covering the whole address space means the PC simply wraps.
  localparam bit          WRAP  = (PC_LIMIT >= (1 << PC_W));
  localparam logic [PC_W:0] LIMIT = (PC_W + 1)'(PC_LIMIT);

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W:0]   pc_inc;
  logic            push;
  logic            pop;
  entry_t          push_data;
  entry_t          head;
  logic [1:0]      count;
  logic            full;
  logic            empty;

  assign pc_inc    = {1'b0, pc_q} + {{PC_W{1'b0}}, 1'b1};
  assign pop       = (count != 2'd0) && out_ready && !redirect_valid;
  assign push_data = '{pc: pc_q, instr: imem_instr};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    if (redirect_valid) begin
      pc_d    = redirect_pc;
      state_d = (WRAP || ({1'b0, redirect_pc} < LIMIT)) ? RUN : DONE;
    end else if (state_q == RUN && (!full || pop)) begin
      push = 1'b1;
      pc_d = pc_inc[PC_W-1:0];
      if (!WRAP && pc_inc == LIMIT) begin
        state_d = DONE;
      end
    end
  end

  fetch_buffer #(
    .entry_t (entry_t)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign imem_pc    = pc_q;
  assign out_valid  = !empty;
  assign out_instr  = head.instr;
  assign out_pc     = head.pc;
  assign fetch_done = (state_q == DONE);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a combinational instruction-memory model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  imem_pc;
  logic [15:0] imem_instr;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [7:0]  out_pc;
  logic        fetch_done;

  logic [15:0] mem [256];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  assign imem_instr = mem[imem_pc];

  fetch_stage #(
    .PC_W     (8),
    .INSTR_W  (16),
    .RESET_PC (8'd0),
    .PC_LIMIT (32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_pc        (imem_pc),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fetch_done     (fetch_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 8'd0;
    out_ready      = rdy;
    step();
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'hA000 + 16'(i);
    mem[0] = 16'h1012;
    mem[1] = 16'h1013;
    mem[2] = 16'h10B4;

    // reset values
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 8'd0; out_ready = 1'b0;
    step();
    step();
    chk("rst_imem_pc", 32'(imem_pc), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_instr", 32'(out_instr), 32'h0);
    chk("rst_pc", 32'(out_pc), 32'h0);
    chk("rst_done", 32'(fetch_done), 32'h0);

    // straight-line run
    rst = 1'b0; out_ready = 1'b1;
    step();
    chk("line_v1", 32'(out_valid), 32'h1);
    chk("line_pc0", 32'(out_pc), 32'h0);
    chk("line_i0", 32'(out_instr), 32'h1012);
    step();
    chk("line_pc1", 32'(out_pc), 32'h1);
    chk("line_i1", 32'(out_instr), 32'h1013);
    step();
    chk("line_pc2", 32'(out_pc), 32'h2);
    chk("line_i2", 32'(out_instr), 32'h10B4);

    // back-pressure
    do_reset(1'b0);
    step(); step(); step(); step();
    chk("bp_imem_pc", 32'(imem_pc), 32'h2);
    chk("bp_valid", 32'(out_valid), 32'h1);
    chk("bp_instr", 32'(out_instr), 32'h1012);
    chk("bp_pc", 32'(out_pc), 32'h0);
    out_ready = 1'b1;
    step();
    chk("bp_rel_pc1", 32'(out_pc), 32'h1);
    step();
    chk("bp_rel_pc2", 32'(out_pc), 32'h2);
    chk("bp_rel_i2", 32'(out_instr), 32'h10B4);
    step();
    chk("bp_rel_pc3", 32'(out_pc), 32'h3);
    chk("bp_rel_i3", 32'(out_instr), 32'hA003);

    // redirect flush with a full buffer
    do_reset(1'b0);
    step(); step(); step();
    redirect_valid = 1'b1; redirect_pc = 8'd6;
    step();
    redirect_valid = 1'b0;
    chk("rd_valid_c4", 32'(out_valid), 32'h0);
    chk("rd_imem_pc", 32'(imem_pc), 32'h6);
    step();
    chk("rd_valid_c5", 32'(out_valid), 32'h1);
    chk("rd_pc6", 32'(out_pc), 32'h6);
    chk("rd_i6", 32'(out_instr), 32'hA006);
    out_ready = 1'b1;
    step();
    chk("rd_pc7", 32'(out_pc), 32'h7);

    // end of memory
    do_reset(1'b1);
    for (int k = 1; k <= 32; k++) begin
      step();
      chk("eom_valid", 32'(out_valid), 32'h1);
      chk("eom_pc", 32'(out_pc), 32'(k - 1));
      chk("eom_instr", 32'(out_instr), 32'(mem[k - 1]));
      if (k == 31) chk("eom_not_done", 32'(fetch_done), 32'h0);
    end
    chk("eom_done", 32'(fetch_done), 32'h1);
    chk("eom_imem_pc", 32'(imem_pc), 32'd32);
    step();
    chk("eom_drained", 32'(out_valid), 32'h0);
    chk("eom_done_hold", 32'(fetch_done), 32'h1);
    chk("eom_pc_hold", 32'(imem_pc), 32'd32);
    redirect_valid = 1'b1; redirect_pc = 8'd4;
    step();
    redirect_valid = 1'b0;
    chk("eom_restart_done", 32'(fetch_done), 32'h0);
    chk("eom_restart_pc", 32'(imem_pc), 32'h4);
    chk("eom_restart_v", 32'(out_valid), 32'h0);
    step();
    chk("eom_restart_out", 32'(out_pc), 32'h4);
    chk("eom_restart_ov", 32'(out_valid), 32'h1);

    // out-of-range redirect
    redirect_valid = 1'b1; redirect_pc = 8'd40;
    step();
    redirect_valid = 1'b0;
    chk("oor_done", 32'(fetch_done), 32'h1);
    chk("oor_valid", 32'(out_valid), 32'h0);
    chk("oor_imem_pc", 32'(imem_pc), 32'd40);
    step();
    chk("oor_valid2", 32'(out_valid), 32'h0);
    chk("oor_imem_pc2", 32'(imem_pc), 32'd40);

    // mid-run reset with two buffered entries
    do_reset(1'b0);
    step(); step();
    chk("mr_full_pc", 32'(imem_pc), 32'h2);
    rst = 1'b1;
    step();
    chk("mr_valid", 32'(out_valid), 32'h0);
    chk("mr_imem_pc", 32'(imem_pc), 32'h0);
    rst = 1'b0; out_ready = 1'b1;
    step();
    chk("mr_resume_v", 32'(out_valid), 32'h1);
    chk("mr_resume_pc", 32'(out_pc), 32'h0);
    step();
    chk("mr_resume_pc1", 32'(out_pc), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
